// File: rtl/pulse_burst_ctrl_pkg.sv
// Shared state encoding and helpers for the pulse burst sequencer.
package pulse_burst_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DELAY = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   function automatic logic is_busy(state_t s);
      return (s == S_DELAY) || (s == S_HIGH) || (s == S_LOW);
   endfunction

endpackage

// File: rtl/pulse_burst_ctrl_prescaler.sv
// Clock-to-tick divider; clr restarts the count so phases align to entry.
module pulse_burst_ctrl_prescaler #(
   parameter int PRESCALE       = 16,
   parameter int PRESCALE_WIDTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam logic [PRESCALE_WIDTH-1:0] LAST = PRESCALE_WIDTH'(PRESCALE - 1);
   localparam logic [PRESCALE_WIDTH-1:0] ONE  = PRESCALE_WIDTH'(1);

   logic [PRESCALE_WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + ONE;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/pulse_burst_ctrl.sv
// Programmable pulse-burst sequencer: delay, then count pulses on a tick grid.
module pulse_burst_ctrl
   import pulse_burst_ctrl_pkg::*;
#(
   parameter int PRESCALE       = 16,
   parameter int PRESCALE_WIDTH = 4,
   parameter int TWIDTH         = 8,
   parameter int CWIDTH         = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [TWIDTH-1:0] cfg_delay,
   input  logic [TWIDTH-1:0] cfg_width,
   input  logic [TWIDTH-1:0] cfg_period,
   input  logic [CWIDTH-1:0] cfg_count,
   output logic              pulse,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic [CWIDTH-1:0] pulse_idx
);

   state_t            state, nxt;
   logic [TWIDTH-1:0] sh_delay, sh_width, sh_low;
   logic [TWIDTH-1:0] tcnt, plen;
   logic [CWIDTH-1:0] sh_count;
   logic              tick, clr, illegal, accept, phase_end, last;

   assign illegal = (cfg_width == '0) || (cfg_count == '0) ||
                    (cfg_width >= cfg_period);
   assign accept  = (state == S_IDLE) && start && !abort && !illegal;
   assign last    = (pulse_idx == sh_count - CWIDTH'(1));

   always_comb begin
      plen = '0;
      unique case (state)
         S_DELAY: plen = sh_delay;
         S_HIGH:  plen = sh_width;
         S_LOW:   plen = sh_low;
         default: plen = '0;
      endcase
   end

   assign phase_end = tick && (tcnt == plen - TWIDTH'(1));

   always_comb begin
      nxt = state;
      if (abort) begin
         nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:
               if (start && !illegal)
                  nxt = (cfg_delay != '0) ? S_DELAY : S_HIGH;
            S_DELAY: if (phase_end) nxt = S_HIGH;
            S_HIGH:  if (phase_end) nxt = S_LOW;
            S_LOW:   if (phase_end) nxt = last ? S_DONE : S_HIGH;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
         endcase
      end
   end

   // Restarting the divider on every phase change keeps phases exact.
   assign clr = (nxt != state) || (state == S_IDLE);

   pulse_burst_ctrl_prescaler #(
      .PRESCALE       (PRESCALE),
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         tcnt    <= '0;
         pulse   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         state   <= nxt;
         pulse   <= (nxt == S_HIGH);
         busy    <= is_busy(nxt);
         done    <= (nxt == S_DONE);
         cfg_err <= (state == S_IDLE) && start && !abort && illegal;
         if (clr)
            tcnt <= '0;
         else if (tick)
            tcnt <= tcnt + TWIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_delay  <= '0;
         sh_width  <= '0;
         sh_low    <= '0;
         sh_count  <= '0;
         pulse_idx <= '0;
      end else if (accept) begin
         sh_delay  <= cfg_delay;
         sh_width  <= cfg_width;
         sh_low    <= cfg_period - cfg_width;
         sh_count  <= cfg_count;
         pulse_idx <= '0;
      end else if (state == S_LOW && phase_end && !last && !abort) begin
         pulse_idx <= pulse_idx + CWIDTH'(1);
      end
   end

endmodule
